pixel_streamer: RTL and testbench

PIXEL_STREAMER -- requirements
Module: pixel_streamer

---
 rtl/pixel_streamer.sv | 203 ++++++++++++++++++++
 tb/tb_pixel_streamer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_streamer.sv
// Streams an N x N frame line by line with LEAD/TRAIL edge replication for an interpolator.
// Optional macro STREAMER_COL_MODE_EN enables column-order lines; without it col_mode is ignored.
module pixel_streamer #(
  parameter int N     = 16,
  parameter int LEAD  = 8,
  parameter int TRAIL = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        col_mode,
  input  logic [31:0] base_addr,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        out_ready,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        tap_valid,
  output logic [15:0] tap_index,
  output logic        busy,
  output logic        done
);

  localparam int BEATS = LEAD + N + TRAIL;
  localparam int BW    = $clog2(BEATS);
  localparam int CW    = (N > 1) ? $clog2(N) : 1;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [BW-1:0] RD_FIRST  = BW'(LEAD - 1);
  localparam logic [BW-1:0] RD_LAST   = BW'(LEAD + N - 3);
  localparam logic [BW-1:0] RD_OFS    = BW'(LEAD - 2);
  localparam logic [BW-1:0] NEW_FIRST = BW'(LEAD + 1);
  localparam logic [BW-1:0] NEW_LAST  = BW'(LEAD + N - 1);
  localparam logic [BW-1:0] TAP_FIRST = BW'(LEAD + TRAIL);
  localparam logic [CW-1:0] LAST_LINE = CW'(N - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, STREAM, DONE} state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [31:0]   r_base;
  logic [CW-1:0] r_line;
  logic [BW-1:0] r_beat;
  logic [1:0]    r_rdPipe;
  logic [31:0]   r_skid;
  logic          r_skidValid;
  logic [31:0]   r_hold;
  logic          r_stalledPrev;

  logic          w_inStream;
  logic          w_accept;
  logic          w_lastBeat;
  logic          w_newBeat;
  logic          w_pop;
  logic [31:0]   w_fresh;
  logic [31:0]   w_pix;
  logic [CW-1:0] w_rdCol;
  logic [CW-1:0] w_tapCol;
  logic [31:0]   w_offset;
  logic [15:0]   w_tapIdx;

  assign w_inStream = (r_state == STREAM);
  assign w_accept   = w_inStream && out_ready;
  assign w_lastBeat = (r_beat == LAST_BEAT);
  assign w_newBeat  = (r_beat == '0) || ((r_beat >= NEW_FIRST) && (r_beat <= NEW_LAST));

  // A fresh pixel is taken only on the first cycle a beat is shown; stalled repeats replay r_hold.
  assign w_pop   = w_inStream && w_newBeat && !r_stalledPrev;
  assign w_fresh = r_skidValid ? r_skid : mem_data;
  assign w_pix   = (w_newBeat && !r_stalledPrev) ? w_fresh : r_hold;

  assign w_rdCol  = (r_state == FETCH) ? '0 : CW'(r_beat - RD_OFS);
  assign w_tapCol = CW'(r_beat - TAP_FIRST);

`ifdef STREAMER_COL_MODE_EN
  logic r_colMode;

  always_comb begin
    if (r_colMode) begin
      w_offset = 32'(w_rdCol) * 32'(N) + 32'(r_line);
      w_tapIdx = 16'(r_line) + 16'(N) * 16'(w_tapCol);
    end else begin
      w_offset = 32'(r_line) * 32'(N) + 32'(w_rdCol);
      w_tapIdx = 16'(r_line) * 16'(N) + 16'(w_tapCol);
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      r_colMode <= 1'b0;
    else if (r_state == IDLE && start)
      r_colMode <= col_mode;
  end
`else
  logic w_unusedColMode;
  assign w_unusedColMode = col_mode;
  assign w_offset = 32'(r_line) * 32'(N) + 32'(w_rdCol);
  assign w_tapIdx = 16'(r_line) * 16'(N) + 16'(w_tapCol);
`endif

  always_ff @(posedge clock) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_nextState;
  end

  // Outputs are forced to zero for the whole time reset is high, not just after the first edge.
  always_comb begin
    w_nextState = r_state;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    data_out    = r_hold;
    data_valid  = 1'b0;
    tap_valid   = 1'b0;
    tap_index   = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_nextState = FETCH;
      end
      FETCH: begin
        busy   = 1'b1;
        mem_rd = out_ready;
        if (out_ready) w_nextState = WAIT;
      end
      WAIT: begin
        busy        = 1'b1;
        w_nextState = STREAM;
      end
      STREAM: begin
        busy       = 1'b1;
        data_out   = w_pix;
        data_valid = out_ready;
        mem_rd     = out_ready && (r_beat >= RD_FIRST) && (r_beat <= RD_LAST);
        tap_valid  = out_ready && (r_beat >= TAP_FIRST);
        if (tap_valid) tap_index = w_tapIdx;
        if (w_accept && w_lastBeat)
          w_nextState = (r_line == LAST_LINE) ? DONE : FETCH;
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
    if (mem_rd) mem_addr = r_base + w_offset;
    if (reset) begin
      w_nextState = IDLE;
      mem_rd      = 1'b0;
      mem_addr    = '0;
      data_out    = '0;
      data_valid  = 1'b0;
      tap_valid   = 1'b0;
      tap_index   = '0;
      busy        = 1'b0;
      done        = 1'b0;
    end
  end

  // Read data lands two cycles after its strobe; if no beat is waiting for it, it parks in r_skid.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_base        <= '0;
      r_line        <= '0;
      r_beat        <= '0;
      r_rdPipe      <= '0;
      r_skid        <= '0;
      r_skidValid   <= 1'b0;
      r_hold        <= '0;
      r_stalledPrev <= 1'b0;
    end else begin
      r_rdPipe      <= {r_rdPipe[0], mem_rd};
      r_stalledPrev <= w_inStream && !out_ready;
      if (w_inStream) r_hold <= w_pix;

      if (r_rdPipe[1] && !(w_pop && !r_skidValid)) begin
        r_skid      <= mem_data;
        r_skidValid <= 1'b1;
      end else if (w_pop) begin
        r_skidValid <= 1'b0;
      end

      if (r_state == IDLE && start) begin
        r_base <= base_addr;
        r_line <= '0;
      end
      if (r_state == WAIT) r_beat <= '0;
      if (w_accept) begin
        if (w_lastBeat) begin
          r_beat <= '0;
          if (r_line != LAST_LINE) r_line <= r_line + CW'(1);
        end else begin
          r_beat <= r_beat + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_streamer.sv
// Scoreboard bench for pixel_streamer: stimulus queues expected beats and read addresses,
// monitors pop and compare whenever the DUT presents a beat or a read strobe.
module tb_pixel_streamer;

  localparam int N     = 16;
  localparam int LEAD  = 8;
  localparam int TRAIL = 5;
  localparam int BEATS = LEAD + N + TRAIL;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        col_mode;
  logic [31:0] base_addr;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        out_ready;
  logic [31:0] data_out;
  logic        data_valid;
  logic        tap_valid;
  logic [15:0] tap_index;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [31:0] data;
    logic        tv;
    logic [15:0] ti;
  } beat_t;

  beat_t       expQ[$];
  logic [31:0] addrQ[$];
  beat_t       monBeat;
  logic [31:0] monAddr;

  int          nVectors     = 0;
  int          nMiscompares = 0;
  int          readCount    = 0;
  int          doneCount    = 0;
  int          savedDone;
  logic [31:0] ninthAddr    = 32'hFFFF_FFFF;
  logic [31:0] tbBase       = 32'h0;

  logic        rp1v = 1'b0;
  logic        rp2v = 1'b0;
  logic [31:0] rp1a = 32'h0;
  logic [31:0] rp2a = 32'h0;

  pixel_streamer #(.N(N), .LEAD(LEAD), .TRAIL(TRAIL)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .col_mode   (col_mode),
    .base_addr  (base_addr),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .tap_valid  (tap_valid),
    .tap_index  (tap_index),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  // Two-cycle frame memory whose word at base+i holds i.
  always @(posedge clock) begin
    rp1v <= mem_rd;
    rp1a <= mem_addr;
    rp2v <= rp1v;
    rp2a <= rp1a;
  end
  assign mem_data = rp2v ? (rp2a - tbBase) : 32'hDEAD_BEEF;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic colEff(input logic cm);
`ifdef STREAMER_COL_MODE_EN
    return cm;
`else
    return 1'b0 & cm;
`endif
  endfunction

  task automatic pushFrame(input logic [31:0] base, input logic cm);
    logic  colOn;
    int    c;
    int    idx;
    beat_t e;
    colOn = colEff(cm);
    for (int l = 0; l < N; l++) begin
      for (int k = 0; k < N; k++) begin
        idx = colOn ? (k * N + l) : (l * N + k);
        addrQ.push_back(base + 32'(idx));
      end
      for (int b = 0; b < BEATS; b++) begin
        if (b < LEAD)           c = 0;
        else if (b < LEAD + N)  c = b - LEAD;
        else                    c = N - 1;
        idx    = colOn ? (c * N + l) : (l * N + c);
        e.data = 32'(idx);
        e.tv   = (b >= LEAD + TRAIL);
        e.ti   = e.tv ? 16'(colOn ? (l + N * (b - LEAD - TRAIL)) : (l * N + b - LEAD - TRAIL)) : 16'h0;
        expQ.push_back(e);
      end
    end
  endtask

  task automatic applyStimulus(input logic [31:0] base, input logic cm);
    tbBase    = base;
    pushFrame(base, cm);
    readCount = 0;
    base_addr = base;
    col_mode  = cm;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start     = 1'b0;
    base_addr = 32'h5555_0000;
    col_mode  = ~cm;
  endtask

  task automatic waitDone(input int expLat);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 2000) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (n == 1) checkOutput("busy_after_start", 32'(busy), 32'd1);
      if (done) seen = 1'b1;
    end
    checkOutput("done_seen", 32'(seen), 32'd1);
    checkOutput("frame_latency", 32'(n), 32'(expLat));
    @(posedge clock);
    @(negedge clock);
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("idle_after_done", 32'(busy), 32'd0);
    checkOutput("beats_left", 32'(expQ.size()), 32'd0);
    checkOutput("reads_left", 32'(addrQ.size()), 32'd0);
    checkOutput("read_count", 32'(readCount), 32'(N * N));
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_busy"},      32'(busy),       32'd0);
    checkOutput({tag, "_done"},      32'(done),       32'd0);
    checkOutput({tag, "_valid"},     32'(data_valid), 32'd0);
    checkOutput({tag, "_mem_rd"},    32'(mem_rd),     32'd0);
    checkOutput({tag, "_mem_addr"},  mem_addr,        32'd0);
    checkOutput({tag, "_data_out"},  data_out,        32'd0);
    checkOutput({tag, "_tap_valid"}, 32'(tap_valid),  32'd0);
    checkOutput({tag, "_tap_index"}, 32'(tap_index),  32'd0);
  endtask

  always @(negedge clock) begin
    if (data_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("beat_unexpected", 32'(data_valid), 32'd0);
      end else begin
        monBeat = expQ.pop_front();
        checkOutput("beat_data", data_out, monBeat.data);
        checkOutput("beat_tap_valid", 32'(tap_valid), 32'(monBeat.tv));
        if (monBeat.tv) checkOutput("beat_tap_index", 32'(tap_index), 32'(monBeat.ti));
      end
    end else if (tap_valid) begin
      checkOutput("tap_without_beat", 32'(tap_valid), 32'd0);
    end
    if (mem_rd) begin
      if (readCount == 8) ninthAddr = mem_addr;
      readCount++;
      if (addrQ.size() == 0) begin
        checkOutput("read_unexpected", 32'(mem_rd), 32'd0);
      end else begin
        monAddr = addrQ.pop_front();
        checkOutput("read_addr", mem_addr, monAddr);
      end
    end
    if (done) doneCount++;
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b1;
    out_ready = 1'b1;
    col_mode  = 1'b0;
    base_addr = 32'h0;

    repeat (3) begin
      @(posedge clock);
      @(negedge clock);
      checkZero("reset");
    end

    // Start is already high as reset drops, so it is sampled on the very first free cycle.
    @(posedge clock);
    #1;
    reset = 1'b0;
    $display("[TB] row-mode ramp frame, late start ignored while busy");
    applyStimulus(32'h0000_0100, 1'b0);
    fork
      waitDone(N * (2 + BEATS));
      begin
        repeat (50) @(posedge clock);
        #1;
        start     = 1'b1;
        base_addr = 32'h0000_0000;
        col_mode  = 1'b1;
        @(posedge clock);
        #1;
        start     = 1'b0;
      end
    join

    $display("[TB] col_mode=1 frame");
    applyStimulus(32'h0000_0100, 1'b1);
    waitDone(N * (2 + BEATS));

    $display("[TB] out_ready stall of 3 cycles at beat 10 of line 0");
    applyStimulus(32'h0000_0100, 1'b0);
    fork
      waitDone(N * (2 + BEATS) + 3);
      begin
        repeat (12) @(posedge clock);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clock);
          checkOutput("stall_valid", 32'(data_valid), 32'd0);
          checkOutput("stall_hold", data_out, 32'd2);
          checkOutput("stall_no_read", 32'(mem_rd), 32'd0);
          @(posedge clock);
        end
        #1;
        out_ready = 1'b1;
      end
    join

    $display("[TB] base address wrap");
    applyStimulus(32'hFFFF_FFF8, 1'b0);
    waitDone(N * (2 + BEATS));
    checkOutput("wrap_addr_row0_col8", ninthAddr, 32'h0000_0000);

    $display("[TB] reset at beat 20 of line 3, then replay");
    applyStimulus(32'h0000_0100, 1'b0);
    repeat (3 * (2 + BEATS) + 2 + 20) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checkZero("abort");
    expQ.delete();
    addrQ.delete();
    savedDone = doneCount;
    repeat (6) @(negedge clock);
    checkOutput("abort_no_done", 32'(doneCount), 32'(savedDone));
    checkOutput("abort_idle", 32'(busy), 32'd0);
    @(posedge clock);
    #1;
    applyStimulus(32'h0000_0100, 1'b0);
    waitDone(N * (2 + BEATS));

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
